serial_add_ctrl: RTL and testbench

//   Bit-serial adder sequencer. Adds two WIDTH-bit operands plus carry-in using
//   one external 1-bit full adder (fullAdder_1b), one bit per cycle, LSB first.

---
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds an external 1-bit full adder LSB first and
// assembles the WIDTH-bit sum plus final carry, with a start/ready/done handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    done_d  = 1'b0;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          count_d = '0;
          sum_d   = '0;
          c_out_d = 1'b0;
          state_d = RUN;
          ready_d = 1'b0;
        end
      end
      RUN: begin
        // Result bits enter at the MSB so bit 0 lands at sum[0] after WIDTH shifts.
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
        carry_d          = fa_cout;
        a_sh_d           = a_sh_q >> 1;
        b_sh_d           = b_sh_q >> 1;
        count_d          = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          c_out_d = fa_cout;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Adder inputs are gated so the shared full adder sees zeros outside RUN.
  assign fa_a   = (state_q == RUN) & a_sh_q[0];
  assign fa_b   = (state_q == RUN) & b_sh_q[0];
  assign fa_cin = (state_q == RUN) & carry_q;

  assign ready = ready_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural 1-bit full adder.
module tb_serial_add_ctrl;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             c_in = 1'b0;
  logic             ready, done, c_out;
  logic [WIDTH-1:0] sum;
  logic             fa_a, fa_b, fa_cin, fa_s, fa_cout;

  int n_chk = 0, n_fail = 0, n_done = 0;
  int cyc = 0, prev_acc = 0;
  logic hold_mode = 1'b0, prev_hold = 1'b0;
  logic [WIDTH:0] exp_q[$];
  int             acc_q[$];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
    .ready(ready), .done(done), .sum(sum), .c_out(c_out),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout)
  );

  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Accept side: expected result is computed from the operands on the accepting edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else if (ready === 1'b1 && start) begin
      exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in});
      acc_q.push_back(cyc);
      if (hold_mode && prev_hold) chk("accept_gap", cyc - prev_acc, WIDTH + 2);
      prev_acc  <= cyc;
      prev_hold <= hold_mode;
    end
  end

  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        chk("result", {c_out, sum}, exp_q.pop_front());
        chk("latency", cyc - acc_q.pop_front() - 1, WIDTH);
        chk("ready_in_done", ready, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic ci);
    int i;
    for (i = 0; i < 100 && ready !== 1'b1; i++) step();
    if (ready !== 1'b1) chk("ready_timeout", 0, 1);
    a = av; b = bv; c_in = ci; start = 1'b1;
    step();
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
  endtask

  task automatic wait_done();
    int target = n_done + 1;
    for (int i = 0; i < 60 && n_done < target; i++) @(posedge clk);
    if (n_done < target) chk("done_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    // Reset
    step(); step();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);
    chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
    rst = 1'b0;
    step();

    // Full carry ripple
    do_add(16'hFFFF, 16'h0001, 1'b0);
    wait_done(); #1;
    chk("ripple_sum", sum, 16'h0000);
    chk("ripple_cout", c_out, 1);
    chk("ripple_ready_back", ready, 1);
    chk("done_one_cycle", done, 0);

    // Sum held while idle with inputs wiggling
    do_add(16'h1234, 16'h4321, 1'b1);
    wait_done(); #1;
    chk("basic_sum", sum, 16'h5556);
    chk("basic_cout", c_out, 0);
    for (int i = 0; i < 10; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      step();
      chk("idle_hold", {c_out, sum}, 17'h05556);
    end

    // Start held high: one accept per WIDTH+2 cycles
    hold_mode = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 4 * (WIDTH + 2); i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
      step();
    end
    start = 1'b0;
    hold_mode = 1'b0;
    drain();

    // Abort mid-run
    do_add(16'hAAAA, 16'h5555, 1'b1);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", c_out, 0);
    chk("abort_fa", {fa_a, fa_b, fa_cin}, 0);
    repeat (WIDTH + 4) step();
    do_add(16'h00FF, 16'h0001, 1'b0);
    wait_done(); #1;
    chk("post_abort_sum", sum, 16'h0100);
    chk("post_abort_cout", c_out, 0);

    // Random soak
    for (int i = 0; i < 1000; i++)
      do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
